// File: rtl/obj_update_sched.sv
// obj_update_sched
// Frame-synchronous update scheduler for the overlay objects. Clients post new
// object position/enable values through valid/ready handshakes; a round-robin
// arbiter writes them into per-slot shadow registers. Once per frame, at the
// start of vertical blanking, every dirty shadow slot is copied into the active
// registers that feed the drawing stages. A frame therefore never shows a
// partially updated object set.
//
// Ports
//   clk           pixel clock
//   rst           asynchronous reset, active low
//   vblnk_in      vertical blanking flag from the timing generator
//   req_valid     per-client request (held until accepted)
//   req_ready     per-client grant, combinational, one-hot or zero
//   req_xpos      packed x positions, slot i at [i*XW +: XW]
//   req_ypos      packed y positions, slot i at [i*YW +: YW]
//   req_en        requested object enables
//   obj_xpos      committed x positions
//   obj_ypos      committed y positions
//   obj_en        committed enables
//   commit_pulse  high during the COMMIT cycle
//   frame_cnt     number of commits, modulo 256
//
// state  | meaning
// ACTIVE | active video; waiting for vblnk_in to rise
// COMMIT | single cycle; dirty shadow slots are copied to active at its end
// BLANK  | inside vertical blanking; waiting for vblnk_in to fall
module obj_update_sched #(
  parameter int N_CLIENTS = 4,
  parameter int XW        = 11,
  parameter int YW        = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vblnk_in,
  input  logic [N_CLIENTS-1:0]    req_valid,
  output logic [N_CLIENTS-1:0]    req_ready,
  input  logic [N_CLIENTS*XW-1:0] req_xpos,
  input  logic [N_CLIENTS*YW-1:0] req_ypos,
  input  logic [N_CLIENTS-1:0]    req_en,
  output logic [N_CLIENTS*XW-1:0] obj_xpos,
  output logic [N_CLIENTS*YW-1:0] obj_ypos,
  output logic [N_CLIENTS-1:0]    obj_en,
  output logic                    commit_pulse,
  output logic [7:0]              frame_cnt
);

  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COMMIT = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N_CLIENTS-1:0][XW-1:0] w_req_x;
  logic [N_CLIENTS-1:0][YW-1:0] w_req_y;
  logic [N_CLIENTS-1:0][XW-1:0] r_sh_x;
  logic [N_CLIENTS-1:0][YW-1:0] r_sh_y;
  logic [N_CLIENTS-1:0][XW-1:0] r_act_x;
  logic [N_CLIENTS-1:0][YW-1:0] r_act_y;
  logic [N_CLIENTS-1:0]         r_sh_en;
  logic [N_CLIENTS-1:0]         r_act_en;
  logic [N_CLIENTS-1:0]         r_dirty;
  logic [N_CLIENTS-1:0]         w_elig;
  logic [N_CLIENTS-1:0]         w_gnt;
  logic [PW-1:0]                r_ptr;
  logic [PW-1:0]                w_gnt_idx;
  logic [PW-1:0]                w_cand;
  logic                         w_gnt_any;
  logic                         w_commit;
  logic [7:0]                   r_frame_cnt;

  assign w_req_x  = req_xpos;
  assign w_req_y  = req_ypos;
  assign w_elig   = req_valid & ~r_dirty;
  assign w_commit = (r_state == COMMIT);

  // Round-robin search starting one past the last winner; a dirty slot is
  // never eligible, so each client gets at most one update per frame.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    w_cand    = r_ptr;
    w_gnt     = '0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % N_CLIENTS);
      if (!w_gnt_any && w_elig[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= BLANK;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACTIVE:  if (vblnk_in) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = vblnk_in ? BLANK : ACTIVE;
      BLANK:   if (!vblnk_in) w_state_nxt = ACTIVE;
      default: w_state_nxt = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_sh_en     <= '0;
      r_act_x     <= '0;
      r_act_y     <= '0;
      r_act_en    <= '0;
      r_dirty     <= '0;
      r_ptr       <= PW'(N_CLIENTS - 1);
      r_frame_cnt <= '0;
    end else begin
      if (w_commit) begin
        for (int i = 0; i < N_CLIENTS; i++) begin
          if (r_dirty[i]) begin
            r_act_x[i]  <= r_sh_x[i];
            r_act_y[i]  <= r_sh_y[i];
            r_act_en[i] <= r_sh_en[i];
          end
        end
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      // A slot granted during COMMIT was clean, so it is not copied above;
      // its shadow write lands here and it commits in the next frame.
      if (w_gnt_any) begin
        r_sh_x[w_gnt_idx]  <= w_req_x[w_gnt_idx];
        r_sh_y[w_gnt_idx]  <= w_req_y[w_gnt_idx];
        r_sh_en[w_gnt_idx] <= req_en[w_gnt_idx];
        r_ptr              <= w_gnt_idx;
      end
      r_dirty <= (w_commit ? '0 : r_dirty) | w_gnt;
    end
  end

  assign req_ready    = w_gnt;
  assign obj_xpos     = r_act_x;
  assign obj_ypos     = r_act_y;
  assign obj_en       = r_act_en;
  assign commit_pulse = w_commit;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_obj_update_sched.sv
// Bench for obj_update_sched: directed vector table, hand-written corner
// sequences (counter wrap, reset mid-frame) and a randomized run, all checked
// against a frame-level reference model of the scheduler.
module tb_obj_update_sched;
  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            vblnk_in;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*XW-1:0] req_xpos;
  logic [N*YW-1:0] req_ypos;
  logic [N-1:0]    req_en;
  logic [N*XW-1:0] obj_xpos;
  logic [N*YW-1:0] obj_ypos;
  logic [N-1:0]    obj_en;
  logic            commit_pulse;
  logic [7:0]      frame_cnt;

  obj_update_sched #(.N_CLIENTS(N), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_xpos(req_xpos), .req_ypos(req_ypos), .req_en(req_en),
    .obj_xpos(obj_xpos), .obj_ypos(obj_ypos), .obj_en(obj_en),
    .commit_pulse(commit_pulse), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending updates per slot, the values on screen, and
  // whether the current cycle is the frame's commit cycle.
  logic [XW-1:0] m_sh_x [N];
  logic [YW-1:0] m_sh_y [N];
  logic          m_sh_en[N];
  logic [XW-1:0] m_act_x[N];
  logic [YW-1:0] m_act_y[N];
  logic          m_act_en[N];
  bit            m_pend [N];
  int            m_last;
  bit            m_in_video;
  bit            m_commit;
  int            m_frames;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh_x[i] = '0; m_sh_y[i] = '0; m_sh_en[i] = 1'b0;
      m_act_x[i] = '0; m_act_y[i] = '0; m_act_en[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_last     = N - 1;
    m_in_video = 1'b0;
    m_commit   = 1'b0;
    m_frames   = 0;
  endtask

  function automatic int model_grant();
    int  r;
    bit  found;
    r = -1;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (!found && req_valid[idx] && !m_pend[idx]) begin
        found = 1'b1;
        r = idx;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input int g, input logic v);
    if (m_commit) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i]) begin
          m_act_x[i] = m_sh_x[i]; m_act_y[i] = m_sh_y[i]; m_act_en[i] = m_sh_en[i];
        end
        m_pend[i] = 1'b0;
      end
      m_frames = m_frames + 1;
    end
    if (g >= 0) begin
      m_sh_x[g]  = req_xpos[g*XW +: XW];
      m_sh_y[g]  = req_ypos[g*YW +: YW];
      m_sh_en[g] = req_en[g];
      m_pend[g]  = 1'b1;
      m_last     = g;
    end
    if (m_commit) begin
      m_commit   = 1'b0;
      m_in_video = !v;
    end else if (m_in_video && v) begin
      m_commit   = 1'b1;
      m_in_video = 1'b0;
    end else if (!m_in_video && !v) begin
      m_in_video = 1'b1;
    end
  endtask

  function automatic logic [N*XW-1:0] exp_x();
    logic [N*XW-1:0] r;
    for (int i = 0; i < N; i++) r[i*XW +: XW] = m_act_x[i];
    return r;
  endfunction

  function automatic logic [N*YW-1:0] exp_y();
    logic [N*YW-1:0] r;
    for (int i = 0; i < N; i++) r[i*YW +: YW] = m_act_y[i];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_act_en[i];
    return r;
  endfunction

  // Called in the low phase with inputs already set; checks, then advances
  // the model across the next rising edge and returns at the falling edge.
  task automatic tick(output int g);
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("commit_pulse", 64'(commit_pulse), 64'(m_commit));
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames % 256));
    check("obj_xpos", 64'(obj_xpos), 64'(exp_x()));
    check("obj_ypos", 64'(obj_ypos), 64'(exp_y()));
    check("obj_en", 64'(obj_en), 64'(exp_en()));
    @(posedge clk);
    model_edge(g, vblnk_in);
    @(negedge clk);
  endtask

  task automatic set_all(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic en);
    for (int i = 0; i < N; i++) begin
      req_xpos[i*XW +: XW] = x;
      req_ypos[i*YW +: YW] = y;
      req_en[i] = en;
    end
  endtask

  typedef struct {
    logic          v;
    logic [N-1:0]  valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          en;
    logic [N-1:0]  exp_ready;
    logic          exp_commit;
    logic [7:0]    exp_fc;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [N-1:0] valid, input int x, input int y,
                              input logic en, input logic [N-1:0] rdy, input logic cp, input int fc);
    vec_t r;
    r.v = v; r.valid = valid; r.x = XW'(x); r.y = YW'(y); r.en = en;
    r.exp_ready = rdy; r.exp_commit = cp; r.exp_fc = 8'(fc);
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    int g;
    int len;
    bit vb;

    rst = 1'b0;
    vblnk_in = 1'b1;
    req_valid = '0;
    set_all('0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_obj_xpos", 64'(obj_xpos), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("reset_commit", 64'(commit_pulse), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    //            v     valid    x    y   en  ready   cp fc
    tbl[0]  = mk(1'b1, 4'b0000,   0,   0, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1'b1, 4'b1111,  11,  12, 1, 4'b0001, 0, 0);
    tbl[2]  = mk(1'b1, 4'b1110,  21,  22, 1, 4'b0010, 0, 0);
    tbl[3]  = mk(1'b0, 4'b1100, 100,  50, 1, 4'b0100, 0, 0);
    tbl[4]  = mk(1'b0, 4'b1000,  41,  42, 1, 4'b1000, 0, 0);
    tbl[5]  = mk(1'b0, 4'b0010,  77,  33, 0, 4'b0000, 0, 0);
    tbl[6]  = mk(1'b1, 4'b0010,  77,  33, 0, 4'b0000, 0, 0);
    tbl[7]  = mk(1'b1, 4'b0010,  77,  33, 0, 4'b0000, 1, 0);
    tbl[8]  = mk(1'b1, 4'b0010,  77,  33, 0, 4'b0010, 0, 1);
    tbl[9]  = mk(1'b0, 4'b0000,   0,   0, 0, 4'b0000, 0, 1);
    tbl[10] = mk(1'b1, 4'b0000,   0,   0, 0, 4'b0000, 0, 1);
    tbl[11] = mk(1'b1, 4'b1000,   5,   5, 1, 4'b1000, 1, 1);
    tbl[12] = mk(1'b0, 4'b0000,   0,   0, 0, 4'b0000, 0, 2);
    tbl[13] = mk(1'b1, 4'b0000,   0,   0, 0, 4'b0000, 0, 2);
    tbl[14] = mk(1'b0, 4'b0000,   0,   0, 0, 4'b0000, 1, 2);
    tbl[15] = mk(1'b0, 4'b0000,   0,   0, 0, 4'b0000, 0, 3);

    for (int r = 0; r < 16; r++) begin
      vblnk_in  = tbl[r].v;
      req_valid = tbl[r].valid;
      set_all(tbl[r].x, tbl[r].y, tbl[r].en);
      #1;
      check($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
      check($sformatf("vec%0d_commit", r), 64'(commit_pulse), 64'(tbl[r].exp_commit));
      check($sformatf("vec%0d_fc", r), 64'(frame_cnt), 64'(tbl[r].exp_fc));
      tick(g);
    end
    check("slot0_x", 64'(obj_xpos[0*XW +: XW]), 64'd11);
    check("slot1_xyen", {obj_xpos[1*XW +: XW], obj_ypos[1*YW +: YW], obj_en[1]}, {11'd77, 11'd33, 1'b0});
    check("slot2_xyen", {obj_xpos[2*XW +: XW], obj_ypos[2*YW +: YW], obj_en[2]}, {11'd100, 11'd50, 1'b1});
    check("slot3_xyen", {obj_xpos[3*XW +: XW], obj_ypos[3*YW +: YW], obj_en[3]}, {11'd5, 11'd5, 1'b1});

    // 253 more vblank rises take frame_cnt from 3 through 255 back to 0
    for (int f = 0; f < 253; f++) begin
      vblnk_in = 1'b1; tick(g); tick(g);
      vblnk_in = 1'b0; tick(g);
    end
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    // reset mid-frame with three dirty slots; client 0 keeps its request up
    req_valid = 4'b0111;
    set_all(11'd9, 11'd9, 1'b1);
    repeat (3) tick(g);
    rst = 1'b0;
    #1;
    check("rst_obj_xpos", 64'(obj_xpos), 64'd0);
    check("rst_obj_ypos", 64'(obj_ypos), 64'd0);
    check("rst_obj_en", 64'(obj_en), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    model_reset();
    req_valid = 4'b0001;
    vblnk_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_regrant", 64'(req_ready), 64'b0001);
    tick(g);
    req_valid = '0;
    vblnk_in = 1'b0; tick(g);
    vblnk_in = 1'b1; tick(g); tick(g);
    vblnk_in = 1'b0; tick(g);
    check("rst_discard_slot1", 64'(obj_xpos[1*XW +: XW]), 64'd0);
    check("rst_discard_slot2", 64'(obj_en[2]), 64'd0);
    check("rst_regrant_commit", {obj_xpos[0*XW +: XW], obj_en[0]}, {11'd9, 1'b1});
    check("rst_frame_one", 64'(frame_cnt), 64'd1);

    // randomized traffic and frame lengths
    vb = 1'b0;
    len = 4;
    for (int c = 0; c < 1500; c++) begin
      if (len == 0) begin
        vb  = !vb;
        len = vb ? $urandom_range(1, 5) : $urandom_range(2, 15);
      end
      len--;
      vblnk_in = vb;
      tick(g);
      for (int i = 0; i < N; i++) begin
        if ((req_valid[i] && g == i) || (!req_valid[i] && ($urandom % 4) == 0)) begin
          req_valid[i] = ($urandom % 3) != 0;
          req_xpos[i*XW +: XW] = XW'($urandom);
          req_ypos[i*YW +: YW] = YW'($urandom);
          req_en[i] = 1'($urandom);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
